dcmac_0_axis_pkt_mon_buffer_ctx: RTL and testbench
==================================================

Name: dcmac_0_axis_pkt_mon_buffer_ctx

Overview:
Receive-side counterpart of the packet-generator buffer context. It tracks, per stream ID, how many bytes of the current 192-byte check word have been accumulated from incoming AXIS beats. For each beat it reports the byte offset where the beat lands and signals when a 192-byte word completes. On end-of-packet it flushes the partial word. It sits between the DCMAC RX AXIS de-framer and the packet-monitor payload checker.

Parameters:
NUM_ID, 6, number of independent stream IDs; ID_W = 1 if NUM_ID==1, else $clog2(NUM_ID)
WORD_BYTES, 192, check-word size in bytes; WORD_BYTES must be <= 255

Ports:
clk  input  1  single clock, all logic on its rising edge
rst  input  1  synchronous, active-high reset
i_valid  input  1  beat valid
i_id  input  ID_W  stream ID of the beat
i_size  input  8  valid bytes in the beat, legal range 1..WORD_BYTES
i_eop  input  1  beat is the last beat of its packet
o_valid  output  1  result valid, 2 cycles after i_valid
o_id  output  ID_W  ID of the result
o_wr_idx  output  8  byte offset in the check word where the beat's first byte lands (fill before the beat)
o_word_done  output  1  a full WORD_BYTES word completed with this beat
o_carry  output  8  bytes of this beat that spill into the next word (valid when o_word_done)
o_flush  output  1  eop flush of a non-empty partial word
o_flush_bytes  output  8  byte count of the flushed partial word
o_err  output  1  illegal i_size (0 or > WORD_BYTES); beat discarded

Behaviour:
- Context: per-ID fill[7:0], range 0..WORD_BYTES-1, held in a register array. Reset clears every fill to 0.
- Reset values: o_valid, o_word_done, o_flush and o_err are 0; o_id, o_wr_idx, o_carry and o_flush_bytes are 0. rst asserted mid-operation clears the pipeline and all context; beats in flight are dropped and produce no o_valid.
- Pipeline stage S1 (cycle after i_valid): register id, size, eop, valid and err. Read fill[id].
- Pipeline stage S2 (second cycle): compute sum = fill + size at 9 bits (max 191+192 = 383).
  - o_wr_idx = fill.
  - If sum >= WORD_BYTES: o_word_done = 1, o_carry = sum - WORD_BYTES, nf = sum - WORD_BYTES.
  - Otherwise: o_word_done = 0, o_carry = 0, nf = sum.
  - If eop and nf != 0: o_flush = 1, o_flush_bytes = nf, and fill[id] is written to 0.
  - If eop and nf == 0: o_flush = 0 and fill[id] is written to 0.
  - If not eop: fill[id] is written to nf.
  - A beat can assert o_word_done and o_flush together.
- Latency: fixed 2 cycles from i_valid to o_valid; throughput is one beat per cycle across any ID mix.
- Hazard forwarding: if the S1 beat has the same ID as the S2 beat that is writing back this cycle, S1 uses the S2 write value, not the array contents. Back-to-back same-ID beats must behave exactly as if spaced apart.
- Error beats: i_size == 0 or i_size > WORD_BYTES gives o_valid = 1 and o_err = 1. In that case o_word_done = o_flush = 0, o_wr_idx = current fill, context is not updated, and forwarding passes the unchanged fill.
- i_eop on an error beat is ignored.
- No backpressure: the block is always ready.
- i_id >= NUM_ID is treated as an error beat (o_err = 1).

Decomposition:
- Shared package dcmac_0_pkt_mon_pkg holds WORD_BYTES_DEF = 192 and a typedef for the S1->S2 beat struct (id, size, eop, err).
- No sub-module: the context array and forwarding mux are inline.

Test Plan:
- ID0 beats of size 64, 64, 64 -> o_wr_idx 0, 64, 128; o_word_done only on the third beat, o_carry = 0; fill returns to 0.
- ID2 beats of size 150 then 100 (back-to-back) -> second result o_wr_idx = 150, o_word_done = 1, o_carry = 58; next ID2 beat o_wr_idx = 58, confirming forwarding.
- ID1 size 100 then size 30 with eop -> o_flush = 1, o_flush_bytes = 130; next ID1 beat o_wr_idx = 0.
- ID3 at fill 191 receives a size-192 beat with eop -> o_word_done = 1, o_carry = 191, o_flush = 1, o_flush_bytes = 191.
- Interleaved IDs 0/1/0/1 with size 96 every cycle -> each ID completes a word on its second beat; no cross-ID corruption.
- Size 0, size 200 and id = 6 -> o_err = 1 two cycles later, context unchanged. Assert rst mid-stream -> no o_valid for in-flight beats, and all IDs restart at o_wr_idx 0.

Source files
------------

// File: rtl/dcmac_0_pkt_mon_pkg.sv
// Shared definitions for the DCMAC packet-monitor blocks.
//   WORD_BYTES_DEF : default check-word size in bytes
//   beat_t         : one beat as it travels from the input stage to the result stage
package dcmac_0_pkt_mon_pkg;

  localparam int WORD_BYTES_DEF = 192;

  // The id field is a fixed 8 bits so that the struct does not depend on NUM_ID.
  // Out-of-range IDs survive intact, and the pipeline can compare them.
  typedef struct packed {
    logic [7:0] id;
    logic [7:0] size;
    logic       eop;
    logic       err;
  } beat_t;

endpackage

// File: rtl/dcmac_0_axis_pkt_mon_buffer_ctx.sv
// Per-stream check-word fill tracker for the RX packet monitor.
// For every AXIS beat, this block reports where the beat lands in the current
// WORD_BYTES check word. It reports whether the beat completes that word and how
// many bytes spill over. It also reports the partial word flushed at end of packet.
// Ports:
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   i_valid/i_id/i_size/i_eop : incoming beat (always accepted)
//   o_valid/o_id  : result, two cycles after the beat
//   o_wr_idx      : fill level before the beat
//   o_word_done/o_carry       : word completed, bytes spilled into next word
//   o_flush/o_flush_bytes     : end-of-packet flush of a non-empty partial word
//   o_err         : illegal size or ID; beat discarded, context untouched
module dcmac_0_axis_pkt_mon_buffer_ctx
  import dcmac_0_pkt_mon_pkg::*;
#(
  parameter  int NUM_ID     = 6,
  parameter  int WORD_BYTES = WORD_BYTES_DEF,
  localparam int ID_W       = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [ID_W-1:0] i_id,
  input  logic [7:0]      i_size,
  input  logic            i_eop,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id,
  output logic [7:0]      o_wr_idx,
  output logic            o_word_done,
  output logic [7:0]      o_carry,
  output logic            o_flush,
  output logic [7:0]      o_flush_bytes,
  output logic            o_err
);

  localparam logic [7:0] WB8     = 8'(WORD_BYTES);
  localparam logic [8:0] WB9     = 9'(WORD_BYTES);
  localparam logic [8:0] NUM_ID9 = 9'(NUM_ID);

  logic       s1_valid_q, s1_valid_d;
  beat_t      s1_beat_q,  s1_beat_d;
  logic       s2_valid_q, s2_valid_d;
  beat_t      s2_beat_q,  s2_beat_d;
  logic [7:0] s2_fill_q,  s2_fill_d;
  logic [7:0] fill_q [NUM_ID];
  logic [7:0] fill_d [NUM_ID];

  logic       s1_in_range, s1_fwd;
  logic [7:0] s1_arr_rd;
  logic [8:0] s2_sum;
  logic       s2_over, s2_live, s2_flush;
  logic [7:0] s2_nf, s2_wr_val;

  // Input stage: qualify the beat. Idle cycles carry an all-zero beat, so the
  // outputs stay at their reset values whenever o_valid is low.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    s1_valid_d = i_valid;
    s1_beat_d  = '0;
    if (i_valid) begin
      s1_beat_d.id   = 8'(i_id);
      s1_beat_d.size = i_size;
      s1_beat_d.eop  = i_eop;
      s1_beat_d.err  = (i_size == 8'd0) || (i_size > WB8) ||
                       ({1'b0, 8'(i_id)} >= NUM_ID9);
    end
  end

  // S1: read the context. If the beat in S2 is writing back the same ID in this
  // cycle, the array value is stale, so the value being written is used instead.
  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_beat_d   = s1_beat_q;
    s1_in_range = {1'b0, s1_beat_q.id} < NUM_ID9;
    s1_arr_rd   = s1_in_range ? fill_q[s1_beat_q.id[ID_W-1:0]] : 8'd0;
    s1_fwd      = s2_live && (s2_beat_q.id == s1_beat_q.id);
    s2_fill_d   = 8'd0;
    if (s1_valid_q) s2_fill_d = s1_fwd ? s2_wr_val : s1_arr_rd;
  end

  // S2: accumulate. fill <= WORD_BYTES-1 and size <= WORD_BYTES, so the wrapped
  // value always fits in 8 bits. The subtraction is therefore done modulo 256.
  always_comb begin
    s2_sum    = {1'b0, s2_fill_q} + {1'b0, s2_beat_q.size};
    s2_over   = s2_sum >= WB9;
    s2_nf     = s2_over ? (s2_sum[7:0] - WB8) : s2_sum[7:0];
    s2_live   = s2_valid_q && !s2_beat_q.err;
    s2_flush  = s2_live && s2_beat_q.eop && (s2_nf != 8'd0);
    s2_wr_val = s2_beat_q.eop ? 8'd0 : s2_nf;
    fill_d    = fill_q;
    if (s2_live) fill_d[s2_beat_q.id[ID_W-1:0]] = s2_wr_val;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_beat_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_beat_q  <= '0;
      s2_fill_q  <= 8'd0;
      // NOTE: the context array is reset explicitly, because every stream must restart at offset 0.
      for (int i = 0; i < NUM_ID; i++) fill_q[i] <= 8'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_beat_q  <= s1_beat_d;
      s2_valid_q <= s2_valid_d;
      s2_beat_q  <= s2_beat_d;
      s2_fill_q  <= s2_fill_d;
      fill_q     <= fill_d;
    end
  end

  assign o_valid       = s2_valid_q;
  assign o_id          = s2_beat_q.id[ID_W-1:0];
  assign o_wr_idx      = s2_fill_q;
  assign o_word_done   = s2_live && s2_over;
  assign o_carry       = (s2_live && s2_over) ? s2_nf : 8'd0;
  assign o_flush       = s2_flush;
  assign o_flush_bytes = s2_flush ? s2_nf : 8'd0;
  assign o_err         = s2_valid_q && s2_beat_q.err;

endmodule

// File: tb/tb_dcmac_0_axis_pkt_mon_buffer_ctx.sv
module tb_dcmac_0_axis_pkt_mon_buffer_ctx;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic [2:0] i_id;
  logic [7:0] i_size;
  logic       i_eop;
  logic       o_valid;
  logic [2:0] o_id;
  logic [7:0] o_wr_idx;
  logic       o_word_done;
  logic [7:0] o_carry;
  logic       o_flush;
  logic [7:0] o_flush_bytes;
  logic       o_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] wr_idx;
    logic       done;
    logic [7:0] carry;
    logic       flush;
    logic [7:0] fbytes;
    logic       err;
  } res_t;

  res_t q[$];

  dcmac_0_axis_pkt_mon_buffer_ctx #(.NUM_ID(6), .WORD_BYTES(192)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_id(i_id), .i_size(i_size),
    .i_eop(i_eop), .o_valid(o_valid), .o_id(o_id), .o_wr_idx(o_wr_idx),
    .o_word_done(o_word_done), .o_carry(o_carry), .o_flush(o_flush),
    .o_flush_bytes(o_flush_bytes), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Capture every result on the falling edge, away from the active edge.
  always @(negedge clk)
    if (o_valid === 1'b1)
      q.push_back('{o_id, o_wr_idx, o_word_done, o_carry, o_flush, o_flush_bytes, o_err});

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(int id, int wr, int done, int carry, int flush, int fb, int err);
    return '{3'(id), 8'(wr), 1'(done), 8'(carry), 1'(flush), 8'(fb), 1'(err)};
  endfunction

  // All drive tasks start and end at posedge+1.
  task automatic beat(input int id, input int size, input int eop);
    i_valid = 1'b1;
    i_id    = 3'(id);
    i_size  = 8'(size);
    i_eop   = 1'(eop);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pop(output res_t r);
    if (q.size() == 0) r = '1;
    else r = q.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; i_id = 3'd1; i_size = 8'd10; i_eop = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_id, o_wr_idx, o_word_done, o_carry, o_flush, o_flush_bytes, o_err} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got valid=%b id=%0d wr=%0d done=%b carry=%0d flush=%b fb=%0d err=%b want all 0",
                 o_valid, o_id, o_wr_idx, o_word_done, o_carry, o_flush, o_flush_bytes, o_err);
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b0; rst = 1'b0;
    idle(4);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL reset_no_valid: got=%0d results want=0", q.size());
    end
    q.delete();
  endtask

  task automatic test_fill_wrap();
    res_t exp[$]; res_t r;
    exp.push_back(mk(0, 0,   0, 0, 0, 0,  0));
    exp.push_back(mk(0, 64,  0, 0, 0, 0,  0));
    exp.push_back(mk(0, 128, 1, 0, 0, 0,  0));
    exp.push_back(mk(0, 0,   0, 0, 1, 10, 0));
    beat(0, 64, 0); beat(0, 64, 0); beat(0, 64, 0); beat(0, 10, 1);
    idle(4);
    for (int k = 0; k < exp.size(); k++) begin
      pop(r); total++;
      if (r !== exp[k]) begin bad++; $display("FAIL fill_wrap[%0d]: got=%h want=%h", k, r, exp[k]); end
    end
  endtask

  task automatic test_back_to_back();
    res_t exp[$]; res_t r;
    exp.push_back(mk(2, 0,   0, 0,  0, 0,  0));
    exp.push_back(mk(2, 150, 1, 58, 0, 0,  0));
    exp.push_back(mk(2, 58,  0, 0,  1, 68, 0));
    beat(2, 150, 0); beat(2, 100, 0); beat(2, 10, 1);
    idle(4);
    for (int k = 0; k < exp.size(); k++) begin
      pop(r); total++;
      if (r !== exp[k]) begin bad++; $display("FAIL back_to_back[%0d]: got=%h want=%h", k, r, exp[k]); end
    end
  endtask

  task automatic test_eop_flush();
    res_t exp[$]; res_t r;
    exp.push_back(mk(1, 0,   0, 0, 0, 0,   0));
    exp.push_back(mk(1, 100, 0, 0, 1, 130, 0));
    exp.push_back(mk(1, 0,   0, 0, 1, 5,   0));
    beat(1, 100, 0); idle(1); beat(1, 30, 1); idle(2); beat(1, 5, 1);
    idle(4);
    for (int k = 0; k < exp.size(); k++) begin
      pop(r); total++;
      if (r !== exp[k]) begin bad++; $display("FAIL eop_flush[%0d]: got=%h want=%h", k, r, exp[k]); end
    end
  endtask

  task automatic test_max_fill();
    res_t exp[$]; res_t r;
    exp.push_back(mk(3, 0,   0, 0,   0, 0,   0));
    exp.push_back(mk(3, 191, 1, 191, 1, 191, 0));
    exp.push_back(mk(3, 0,   0, 0,   1, 1,   0));
    beat(3, 191, 0); beat(3, 192, 1); beat(3, 1, 1);
    idle(4);
    for (int k = 0; k < exp.size(); k++) begin
      pop(r); total++;
      if (r !== exp[k]) begin bad++; $display("FAIL max_fill[%0d]: got=%h want=%h", k, r, exp[k]); end
    end
  endtask

  task automatic test_interleave();
    res_t exp[$]; res_t r;
    exp.push_back(mk(0, 0,  0, 0, 0, 0, 0));
    exp.push_back(mk(1, 0,  0, 0, 0, 0, 0));
    exp.push_back(mk(0, 96, 1, 0, 0, 0, 0));
    exp.push_back(mk(1, 96, 1, 0, 0, 0, 0));
    exp.push_back(mk(0, 0,  0, 0, 1, 3, 0));
    exp.push_back(mk(1, 0,  0, 0, 1, 4, 0));
    beat(0, 96, 0); beat(1, 96, 0); beat(0, 96, 0); beat(1, 96, 0);
    beat(0, 3, 1); beat(1, 4, 1);
    idle(4);
    for (int k = 0; k < exp.size(); k++) begin
      pop(r); total++;
      if (r !== exp[k]) begin bad++; $display("FAIL interleave[%0d]: got=%h want=%h", k, r, exp[k]); end
    end
  endtask

  task automatic test_errors();
    res_t exp[$]; res_t r;
    exp.push_back(mk(4, 0,  0, 0, 0, 0,  0));
    exp.push_back(mk(4, 50, 0, 0, 0, 0,  1));
    exp.push_back(mk(4, 50, 0, 0, 0, 0,  1));
    exp.push_back(mk(6, 0,  0, 0, 0, 0,  1));
    exp.push_back(mk(4, 50, 0, 0, 1, 60, 0));
    beat(4, 50, 0); beat(4, 0, 1); beat(4, 200, 0); beat(6, 10, 1); beat(4, 10, 1);
    idle(4);
    for (int k = 0; k < exp.size(); k++) begin
      pop(r); total++;
      if (r !== exp[k]) begin bad++; $display("FAIL errors[%0d]: got=%h want=%h", k, r, exp[k]); end
    end
  endtask

  task automatic test_mid_reset();
    res_t r; res_t e;
    beat(5, 40, 0);
    idle(4);
    pop(r); e = mk(5, 0, 0, 0, 0, 0, 0); total++;
    if (r !== e) begin bad++; $display("FAIL mid_reset_pre: got=%h want=%h", r, e); end
    // One beat is taken in, and reset hits while a second beat is still being driven.
    i_valid = 1'b1; i_id = 3'd5; i_size = 8'd20; i_eop = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; i_id = 3'd0; i_size = 8'd30;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_dropped: got=%0d results want=0", q.size());
    end
    q.delete();
    for (int id = 0; id < 6; id++) beat(id, 7, 1);
    idle(4);
    for (int id = 0; id < 6; id++) begin
      pop(r); e = mk(id, 0, 0, 0, 1, 7, 0); total++;
      if (r !== e) begin bad++; $display("FAIL mid_reset_restart[%0d]: got=%h want=%h", id, r, e); end
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_id = '0; i_size = '0; i_eop = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fill_wrap();
    test_back_to_back();
    test_eop_flush();
    test_max_fill();
    test_interleave();
    test_errors();
    test_mid_reset();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL leftover_results: got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
